// File: rtl/pronoc_pkg.sv
// Shared router types and helpers used by the tree router blocks.
package pronoc_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } uplink_state_e;

  // Width of a counter that must hold every value 0..depth.
  function automatic int unsigned credit_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of an index into n entries (never zero).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tree_rr_arbiter.sv
// Round-robin priority select: first request at or above rr_ptr, wrapping mod K.
module tree_rr_arbiter
  import pronoc_pkg::*;
#(
  parameter int unsigned K = 4
) (
  input  logic [K-1:0]          req,
  input  logic [idx_w(K)-1:0]   rr_ptr,
  output logic [K-1:0]          grant
);

  localparam int unsigned PW = idx_w(K);

  logic          found;
  logic [PW-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sel   = '0;
    for (int unsigned off = 0; off < K; off++) begin
      sel = PW'((32'(rr_ptr) + off) % K);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_uplink_arbiter.sv
// Up-link scheduler: round-robin packet arbitration among K down-ports,
// grant held head-to-tail, gated by credits for the parent input buffer.
module tree_uplink_arbiter
  import pronoc_pkg::*;
#(
  parameter int unsigned K  = 4,
  parameter int unsigned Fw = 32,
  parameter int unsigned B  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [K-1:0]             req_valid,
  input  logic [K-1:0]             req_head,
  input  logic [K-1:0]             req_tail,
  input  logic [K*Fw-1:0]          req_flit,
  output logic [K-1:0]             req_pop,
  input  logic                     credit_in,
  output logic                     up_valid,
  output logic [Fw-1:0]            up_flit,
  output logic [K-1:0]             owner,
  output logic [$clog2(B+1)-1:0]   credit_cnt,
  output logic                     credit_err
);

  localparam int unsigned PW = idx_w(K);
  localparam int unsigned CW = credit_w(B);
  localparam logic [CW-1:0] CRED_FULL = CW'(B);

  uplink_state_e state_q, state_d;
  logic [K-1:0]  owner_q, owner_d;
  logic [PW-1:0] own_idx_q, own_idx_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          up_valid_q, up_valid_d;
  logic [Fw-1:0] up_flit_q, up_flit_d;
  logic          credit_err_q, credit_err_d;

  logic [K-1:0]  grant;
  logic [PW-1:0] grant_idx;
  logic          pop;
  logic [Fw-1:0] pop_flit;

  // Only head flits compete; a body flit at a buffer head is never a candidate.
  tree_rr_arbiter #(.K(K)) u_rr (
    .req    (req_valid & req_head),
    .rr_ptr (rr_ptr_q),
    .grant  (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  always_comb begin
    pop_flit = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (own_idx_q == PW'(i)) pop_flit = req_flit[i*Fw +: Fw];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      own_idx_q    <= '0;
      rr_ptr_q     <= '0;
      credit_q     <= CRED_FULL;
      up_valid_q   <= 1'b0;
      up_flit_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      own_idx_q    <= own_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      up_valid_q   <= up_valid_d;
      up_flit_q    <= up_flit_d;
      credit_err_q <= credit_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    own_idx_d    = own_idx_q;
    rr_ptr_d     = rr_ptr_q;
    credit_d     = credit_q;
    credit_err_d = credit_err_q;
    up_valid_d   = pop;
    up_flit_d    = pop ? pop_flit : up_flit_q;

    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d   = ST_LOCKED;
          owner_d   = grant;
          own_idx_d = grant_idx;
        end
      end
      ST_LOCKED: begin
        if (pop && req_tail[own_idx_q]) begin
          state_d  = ST_IDLE;
          owner_d  = '0;
          rr_ptr_d = (own_idx_q == PW'(K - 1)) ? '0 : own_idx_q + 1'b1;
        end
      end
    endcase

    // Pop and returned credit in the same cycle cancel out.
    if (pop && !credit_in) begin
      credit_d = credit_q - 1'b1;
    end else if (!pop && credit_in) begin
      if (credit_q == CRED_FULL) credit_err_d = 1'b1;
      else                       credit_d     = credit_q + 1'b1;
    end
  end

  always_comb begin
    req_pop = '0;
    if (state_q == ST_LOCKED && credit_q != '0) req_pop[own_idx_q] = req_valid[own_idx_q];
  end

  assign pop        = |req_pop;
  assign up_valid   = up_valid_q;
  assign up_flit    = up_flit_q;
  assign owner      = owner_q;
  assign credit_cnt = credit_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_tree_uplink_arbiter.sv
// Bench for tree_uplink_arbiter: per-port flit queues feed the DUT, a packet-level
// model predicts pops, grants, credits and the up-link stream every cycle.
module tb_tree_uplink_arbiter;

  localparam int K  = 4;
  localparam int FW = 32;
  localparam int B  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [K-1:0]    req_valid, req_head, req_tail, req_pop, owner;
  logic [K*FW-1:0] req_flit;
  logic            credit_in, up_valid, credit_err;
  logic [FW-1:0]   up_flit;
  logic [2:0]      credit_cnt;

  always #5 clk = ~clk;

  tree_uplink_arbiter #(.K(K), .Fw(FW), .B(B)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .req_valid  (req_valid),
    .req_head   (req_head),
    .req_tail   (req_tail),
    .req_flit   (req_flit),
    .req_pop    (req_pop),
    .credit_in  (credit_in),
    .up_valid   (up_valid),
    .up_flit    (up_flit),
    .owner      (owner),
    .credit_cnt (credit_cnt),
    .credit_err (credit_err)
  );

  typedef struct packed {
    logic          head;
    logic          tail;
    logic [FW-1:0] data;
  } flit_t;

  flit_t      fq[K][$];
  logic [K-1:0] stall;
  int         credit_mode;  // 0: test drives credit_in, 1: random returns, 2: return asap
  int         p_used;
  int         checks, errors;

  // Reference state: owner -1 means no packet in progress.
  int            m_owner, m_rr, m_cred;
  bit            m_err, m_upv;
  logic [FW-1:0] m_upf;

  logic [K-1:0] o_pop, o_owner;
  logic         o_upv, o_err;
  logic [2:0]   o_cnt;

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_cred = B; m_err = 0; m_upv = 0; m_upf = '0;
  endtask

  task automatic push_packet(input int port, input int len);
    for (int j = 0; j < len; j++) begin
      flit_t f;
      f.head = (j == 0);
      f.tail = (j == len - 1);
      f.data = $urandom;
      fq[port].push_back(f);
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < K; i++) begin
      if (fq[i].size() > 0 && !stall[i]) begin
        req_valid[i] = 1'b1;
        req_head[i]  = fq[i][0].head;
        req_tail[i]  = fq[i][0].tail;
        req_flit[i*FW +: FW] = fq[i][0].data;
      end else begin
        req_valid[i] = 1'b0;
        req_head[i]  = 1'($urandom % 2);
        req_tail[i]  = 1'($urandom % 2);
        req_flit[i*FW +: FW] = $urandom;
      end
    end
    if (credit_mode == 1)      credit_in = (p_used > 0) && ($urandom % 2 == 1);
    else if (credit_mode == 2) credit_in = (p_used > 0);
  endtask

  // One clock: drive, compare at negedge against the model, advance model past the edge.
  task automatic cycle();
    int            pp, n_owner, n_rr, n_cred;
    bit            n_err, n_upv;
    logic [FW-1:0] n_upf;
    logic [K-1:0]  e_pop, e_owner;
    apply_inputs();
    @(negedge clk);
    pp = -1;
    if (m_owner >= 0 && req_valid[m_owner] && m_cred > 0) pp = m_owner;
    e_pop = '0;   if (pp >= 0)      e_pop[pp] = 1'b1;
    e_owner = '0; if (m_owner >= 0) e_owner[m_owner] = 1'b1;
    o_pop = req_pop; o_owner = owner; o_upv = up_valid; o_err = credit_err; o_cnt = credit_cnt;

    checks += 6;
    if (req_pop !== e_pop) begin errors++; $display("FAIL req_pop @%0t: got %b expected %b", $time, req_pop, e_pop); end
    if (owner !== e_owner) begin errors++; $display("FAIL owner @%0t: got %b expected %b", $time, owner, e_owner); end
    if (credit_cnt !== 3'(m_cred)) begin errors++; $display("FAIL credit_cnt @%0t: got %0d expected %0d", $time, credit_cnt, m_cred); end
    if (up_valid !== m_upv) begin errors++; $display("FAIL up_valid @%0t: got %b expected %b", $time, up_valid, m_upv); end
    if (m_upv && up_flit !== m_upf) begin errors++; $display("FAIL up_flit @%0t: got %h expected %h", $time, up_flit, m_upf); end
    if (credit_err !== m_err) begin errors++; $display("FAIL credit_err @%0t: got %b expected %b", $time, credit_err, m_err); end

    if (!rst_n) begin
      n_owner = -1; n_rr = 0; n_cred = B; n_err = 0; n_upv = 0; n_upf = '0;
    end else begin
      n_owner = m_owner; n_rr = m_rr; n_err = m_err;
      n_upv = (pp >= 0);
      n_upf = (pp >= 0) ? req_flit[pp*FW +: FW] : m_upf;
      n_cred = m_cred - ((pp >= 0) ? 1 : 0) + (credit_in ? 1 : 0);
      if (n_cred > B) begin n_cred = B; n_err = 1; end
      if (m_owner < 0) begin
        for (int off = 0; off < K; off++) begin
          int p;
          p = (m_rr + off) % K;
          if (n_owner < 0 && req_valid[p] && req_head[p]) n_owner = p;
        end
      end else if (pp >= 0 && req_tail[pp]) begin
        n_owner = -1;
        n_rr = (pp + 1) % K;
      end
    end

    @(posedge clk);
    #1;
    m_owner = n_owner; m_rr = n_rr; m_cred = n_cred; m_err = n_err; m_upv = n_upv; m_upf = n_upf;
    if (pp >= 0) begin
      void'(fq[pp].pop_front());
      p_used++;
    end
    if (credit_in && p_used > 0) p_used--;
    if (!rst_n) p_used = 0;
  endtask

  function automatic bit busy();
    bit b;
    b = (m_owner >= 0) || m_upv;
    for (int i = 0; i < K; i++) if (fq[i].size() > 0) b = 1;
    return b;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    stall = '0;
    if (credit_mode == 0) credit_mode = 2;
    while (busy() && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (busy()) begin errors++; $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n); end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < K; i++) fq[i].delete();
    stall = '0; p_used = 0; credit_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = '0; credit_mode = 0; credit_in = 1'b0; p_used = 0;
    apply_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks += 6;
    if (owner !== 4'b0000) begin errors++; $display("FAIL reset_owner: got %b expected 0000", owner); end
    if (credit_cnt !== 3'd4) begin errors++; $display("FAIL reset_credit: got %0d expected 4", credit_cnt); end
    if (up_valid !== 1'b0) begin errors++; $display("FAIL reset_up_valid: got %b expected 0", up_valid); end
    if (up_flit !== 32'h0) begin errors++; $display("FAIL reset_up_flit: got %h expected 0", up_flit); end
    if (credit_err !== 1'b0) begin errors++; $display("FAIL reset_credit_err: got %b expected 0", credit_err); end
    if (req_pop !== 4'b0000) begin errors++; $display("FAIL reset_req_pop: got %b expected 0000", req_pop); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [3:0] ep [6] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic [3:0] eo [6] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic       ev [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    credit_mode = 2;
    push_packet(2, 3);
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks += 3;
      if (o_pop !== ep[c])   begin errors++; $display("FAIL single_pop c%0d: got %b expected %b", c, o_pop, ep[c]); end
      if (o_owner !== eo[c]) begin errors++; $display("FAIL single_owner c%0d: got %b expected %b", c, o_owner, eo[c]); end
      if (o_upv !== ev[c])   begin errors++; $display("FAIL single_up_valid c%0d: got %b expected %b", c, o_upv, ev[c]); end
    end
    // After port 2's tail, port 3 has highest priority.
    for (int i = 0; i < K; i++) push_packet(i, 1);
    cycle();
    cycle();
    checks++;
    if (o_owner !== 4'b1000) begin errors++; $display("FAIL rr_after_tail: got %b expected 1000", o_owner); end
    drain(100);
  endtask

  task automatic test_round_robin();
    int seq[$], tim[$];
    do_reset();
    credit_mode = 2;
    for (int i = 0; i < K; i++) begin push_packet(i, 1); push_packet(i, 1); end
    for (int c = 0; c < 16; c++) begin
      cycle();
      if (o_pop != 0) begin seq.push_back($clog2(o_pop)); tim.push_back(c); end
    end
    checks++;
    if (seq.size() != 8) begin errors++; $display("FAIL rr_pop_count: got %0d expected 8", seq.size()); end
    for (int j = 0; j < seq.size(); j++) begin
      checks++;
      if (seq[j] != j % K) begin errors++; $display("FAIL rr_order[%0d]: got port %0d expected %0d", j, seq[j], j % K); end
      if (j > 0) begin
        checks++;
        if (tim[j] - tim[j-1] != 2) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 2", j, tim[j] - tim[j-1]); end
      end
    end
    drain(100);
  endtask

  task automatic test_lock_hold();
    do_reset();
    credit_mode = 2;
    push_packet(1, 3);
    cycle();
    cycle();
    stall[1] = 1'b1;
    push_packet(0, 1);
    for (int c = 0; c < 3; c++) begin
      cycle();
      checks += 2;
      if (o_owner !== 4'b0010) begin errors++; $display("FAIL lock_owner c%0d: got %b expected 0010", c, o_owner); end
      if (o_pop !== 4'b0000)   begin errors++; $display("FAIL lock_pop c%0d: got %b expected 0000", c, o_pop); end
    end
    stall = '0;
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if (o_pop !== 4'b0010) begin errors++; $display("FAIL lock_resume c%0d: got %b expected 0010", c, o_pop); end
    end
    cycle();
    checks++;
    if (o_pop !== 4'b0000) begin errors++; $display("FAIL lock_rearb_pop: got %b expected 0000", o_pop); end
    cycle();
    checks++;
    if (o_pop !== 4'b0001) begin errors++; $display("FAIL lock_next_owner_pop: got %b expected 0001", o_pop); end
    drain(100);
  endtask

  task automatic test_credit_exhaustion();
    int npops;
    do_reset();
    credit_mode = 0;
    credit_in = 1'b0;
    push_packet(3, 6);
    npops = 0;
    for (int c = 0; c < 7; c++) begin
      cycle();
      if (o_pop == 4'b1000) npops++;
    end
    checks += 3;
    if (npops != 4)        begin errors++; $display("FAIL exhaust_pops: got %0d expected 4", npops); end
    if (o_cnt !== 3'd0)    begin errors++; $display("FAIL exhaust_cnt: got %0d expected 0", o_cnt); end
    if (o_pop !== 4'b0000) begin errors++; $display("FAIL exhaust_pop_blocked: got %b expected 0000", o_pop); end
    credit_in = 1'b1;
    cycle();
    credit_in = 1'b0;
    cycle();
    checks += 2;
    if (o_pop !== 4'b1000) begin errors++; $display("FAIL exhaust_one_more: got %b expected 1000", o_pop); end
    if (o_cnt !== 3'd1)    begin errors++; $display("FAIL exhaust_cnt_one: got %0d expected 1", o_cnt); end
    cycle();
    checks++;
    if (o_pop !== 4'b0000) begin errors++; $display("FAIL exhaust_only_one: got %b expected 0000", o_pop); end
    drain(100);
  endtask

  task automatic test_credit_simultaneous();
    do_reset();
    credit_mode = 0;
    credit_in = 1'b0;
    push_packet(0, 4);
    cycle();
    cycle();
    cycle();
    credit_in = 1'b1;
    cycle();
    checks += 2;
    if (o_cnt !== 3'd2)    begin errors++; $display("FAIL sim_cnt_before: got %0d expected 2", o_cnt); end
    if (o_pop !== 4'b0001) begin errors++; $display("FAIL sim_pop: got %b expected 0001", o_pop); end
    credit_in = 1'b0;
    cycle();
    checks++;
    if (o_cnt !== 3'd2) begin errors++; $display("FAIL sim_cnt_after: got %0d expected 2", o_cnt); end
    credit_in = 1'b1;
    cycle();
    checks++;
    if (o_cnt !== 3'd1) begin errors++; $display("FAIL sim_cnt_tail: got %0d expected 1", o_cnt); end
    cycle();
    cycle();
    cycle();
    checks += 2;
    if (o_cnt !== 3'd4)  begin errors++; $display("FAIL sat_cnt_full: got %0d expected 4", o_cnt); end
    if (o_err !== 1'b0)  begin errors++; $display("FAIL sat_err_early: got %b expected 0", o_err); end
    credit_in = 1'b0;
    cycle();
    checks += 2;
    if (o_cnt !== 3'd4)  begin errors++; $display("FAIL sat_cnt_held: got %0d expected 4", o_cnt); end
    if (o_err !== 1'b1)  begin errors++; $display("FAIL sat_err_set: got %b expected 1", o_err); end
    cycle();
    checks++;
    if (o_err !== 1'b1)  begin errors++; $display("FAIL sat_err_sticky: got %b expected 1", o_err); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    credit_mode = 2;
    push_packet(1, 5);
    cycle();
    cycle();
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < K; i++) fq[i].delete();
    p_used = 0;
    cycle();
    checks += 4;
    if (o_owner !== 4'b0000) begin errors++; $display("FAIL midrst_owner: got %b expected 0000", o_owner); end
    if (o_cnt !== 3'd4)      begin errors++; $display("FAIL midrst_cnt: got %0d expected 4", o_cnt); end
    if (o_upv !== 1'b0)      begin errors++; $display("FAIL midrst_up_valid: got %b expected 0", o_upv); end
    if (o_pop !== 4'b0000)   begin errors++; $display("FAIL midrst_pop: got %b expected 0000", o_pop); end
  endtask

  task automatic test_random();
    do_reset();
    credit_mode = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < K; i++)
        if (fq[i].size() < 8 && $urandom % 6 == 0) push_packet(i, $urandom_range(1, 4));
      stall = 4'($urandom & $urandom);
      cycle();
    end
    drain(400);
  endtask

  initial begin
    checks = 0; errors = 0;
    req_valid = '0; req_head = '0; req_tail = '0; req_flit = '0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_lock_hold();
    test_credit_exhaustion();
    test_credit_simultaneous();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_uplink_arbiter.md
# tree_uplink_arbiter

Packet-level scheduler for the single up-link of a non-root tree router. It shares that up-link among the K down-ports that carry packets toward the root. Arbitration is round-robin and grants are held from head flit to tail flit. It also tracks credits of the parent router's input buffer so no flit is sent without buffer space. It sits between the K down-port input buffers and output port K of each level ≥ 1 router.

## Interface
- K, default 4: number of requesting down-ports (router output port index K is the up-link).
- Fw, default 32: flit payload width.
- B, default 4: parent input buffer depth in flits; initial credit count.
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: one clock; reset is synchronous and active-low.
- req_valid, input, K: down-port i has a flit at its buffer head.
- req_head, input, K: that flit is a head flit.
- req_tail, input, K: that flit is a tail flit; head and tail both set means a single-flit packet.
- req_flit, input, K*Fw: flit payloads; port i occupies bits [i*Fw +: Fw].
- req_pop, output, K: one-hot or zero; pops the head of port i this cycle.
- credit_in, input, 1: parent returned one buffer slot.
- up_valid, output, 1: up_flit is valid this cycle.
- up_flit, output, Fw: flit toward parent.
- owner, output, K: one-hot current grant; zero when idle.
- credit_cnt, output, $clog2(B+1): credits available.
- credit_err, output, 1: sticky; a credit was returned while already at B.

## Operation
- States are IDLE and LOCKED; the enum lives in the shared package.
- IDLE: candidates are all i with req_valid[i] & req_head[i]. Ports whose buffer head is a body flit are ignored.
- The winner is the first candidate at or after rr_ptr, scanning upward with wraparound mod K. The owner register loads the winner and the FSM moves to LOCKED. No pop happens in the arbitration cycle.
- With no candidate, the FSM stays in IDLE.
- LOCKED: req_pop[o] = req_valid[o] & (credit_cnt != 0), where o is the owner. All other pop bits are 0.
- On a pop, the flit is registered to up_flit and up_valid is 1 on the next cycle.
- A pop with req_tail[o] set moves the FSM to IDLE, clears owner, and sets rr_ptr = (o+1) mod K.
- An owner with req_valid low does not release the lock; the FSM stays in LOCKED.
- Credits:
  - credit_cnt decrements on each pop and increments on credit_in.
  - A pop and credit_in in the same cycle leave the count unchanged.
  - credit_in at credit_cnt = B saturates at B and sets credit_err.
  - A pop at credit_cnt = 0 cannot happen by construction.
- credit_err is cleared only by reset.

## Timing
- Reset values:
  - state = IDLE
  - owner = 0
  - rr_ptr = 0
  - credit_cnt = B
  - up_valid = 0
  - up_flit = 0
  - credit_err = 0
  - req_pop = 0 (combinational, gated by state)
- Reset asserted mid-packet discards the lock and credit state in the same edge. The bench re-initialises the parent side.
- Latency from the head flit being visible in IDLE to the first pop is 1 cycle. The head flit appears on up_valid 2 cycles after it became visible.
- Sustained throughput is 1 flit/cycle while credits are nonzero.
- A tail pop followed by re-arbitration costs 1 idle cycle on the up-link; the next grant is made in the cycle after the tail pop.
- req_pop is combinational from registered state, credit_cnt and req_valid. It has no combinational path from credit_in.

## Structure
- The state enum and the credit width function belong in pronoc_pkg, next to the existing router typedefs.
- The round-robin priority selection is a natural sub-module: tree_rr_arbiter, with K-bit request, rr_ptr in, and one-hot grant out.
- The FSM, credit counter and output register stay in tree_uplink_arbiter.
- Target size is about 180 RTL lines.

## Test plan
- Reset then single packet: reset low 2 cycles, then port 2 sends a 3-flit packet (head at cycle 5).
  - Arbitration at cycle 5; pops at cycles 6, 7, 8.
  - up_valid high at cycles 7–9.
  - owner = 4'b0100 during LOCKED; rr_ptr = 3 after the tail.
- Round-robin fairness: all 4 ports continuously offer single-flit packets, with credit_in returned each cycle.
  - Grant order is 0, 1, 2, 3, 0, …
  - One pop every 2 cycles.
- Lock hold: port 1 owns a packet and stalls req_valid for 3 cycles while port 0 has a head waiting.
  - owner stays 4'b0010.
  - No pop to port 0 until after port 1's tail.
- Credit exhaustion: B = 4 and no credit_in while port 3 sends 6 flits.
  - 4 pops, then credit_cnt = 0 and req_pop = 0.
  - One credit_in yields exactly one more pop.
- Simultaneous pop and credit_in at credit_cnt = 2: the count stays 2.
  - An extra credit_in at credit_cnt = 4 sets credit_err and keeps the count at 4.
- Reset mid-packet: assert reset during a LOCKED transfer.
  - On the next edge owner = 0, state = IDLE, credit_cnt = 4, up_valid = 0.
